// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared constants for the seven-segment scan driver: the dark segment
// pattern, the 16-entry hex font (segments a..g, a = MSB, active-low) and a
// lookup helper used by the combinational font decoder.
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    localparam logic [6:0] SEG_DARK = 7'h7F;

    localparam logic [6:0] FONT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0D,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        return FONT[nib];
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver_if
// Bundles the datapath-facing and pin-facing signals of the scan driver.
//   value      4*DIGITS hex digits, digit 0 rightmost
//   dp_in      decimal point request per digit (1 = lit)
//   blank_in   force digit dark (1 = dark)
//   load       one-cycle strobe capturing value/dp_in/blank_in
//   lz_en      leading-zero suppression enable
//   pending    a captured load waits for the next frame boundary
//   frame_tick one-cycle pulse when the scan index wraps to 0
//   seg/dp/an  active-low segment, decimal point and anode outputs
// master = the side driving display data, slave = the driver itself.
// -----------------------------------------------------------------------------
interface sevenseg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic                lz_en;
    logic                pending;
    logic                frame_tick;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    modport master (
        output value, dp_in, blank_in, load, lz_en,
        input  pending, frame_tick, seg, dp, an
    );

    modport slave (
        input  value, dp_in, blank_in, load, lz_en,
        output pending, frame_tick, seg, dp, an
    );
endinterface

// File: rtl/sevenseg_font.sv
// -----------------------------------------------------------------------------
// sevenseg_font
// Purely combinational hex-nibble to seven-segment decoder.
//   i_nibble  hex digit 0..F
//   o_seg     segments a..g, a = MSB, active-low
// -----------------------------------------------------------------------------
module sevenseg_font (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    import sevenseg_pkg::*;

    assign o_seg = seg_font(i_nibble);
endmodule

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
// Time-multiplexed common-anode seven-segment driver. A prescaler divides clk
// into digit slots of REFRESH_DIV clocks; each slot shows one digit of the
// active buffer. Loads land in a pending buffer and are committed to the
// active buffer only at a frame boundary so a frame never mixes two words.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    sevenseg_scan_driver_if.slave (data in, display pins out)
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    sevenseg_scan_driver_if.slave  bus
);
    import sevenseg_pkg::*;

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_pend_val;
    logic [DIGITS-1:0]     r_pend_dp;
    logic [DIGITS-1:0]     r_pend_blank;
    logic [4*DIGITS-1:0]   r_act_val;
    logic [DIGITS-1:0]     r_act_dp;
    logic [DIGITS-1:0]     r_act_blank;
    logic                  r_pending;
    logic                  r_frame_tick;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_an;

    logic                  w_term;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic                  w_blank_sel;
    logic                  w_dp_sel;
    logic                  w_zsup;
    logic                  w_zacc;
    logic                  w_dark;
    logic [6:0]            w_font_seg;

    assign w_term = (r_presc == PW'(REFRESH_DIV - 1));
    // Explicit DIGITS-1 compare keeps non-power-of-two scans in range.
    assign w_wrap = w_term && (r_idx == IW'(DIGITS - 1));

    // Select the current digit and decide leading-zero suppression. The
    // accumulator walks from the most significant digit down, so at digit k
    // it is 1 only if every nibble DIGITS-1..k is zero.
    always_comb begin
        w_nib       = 4'h0;
        w_blank_sel = 1'b0;
        w_dp_sel    = 1'b0;
        w_zsup      = 1'b0;
        w_zacc      = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zacc = w_zacc & (r_act_val[4*k +: 4] == 4'h0);
            if (r_idx == IW'(k)) begin
                w_nib       = r_act_val[4*k +: 4];
                w_blank_sel = r_act_blank[k];
                w_dp_sel    = r_act_dp[k];
                w_zsup      = (k != 0) && w_zacc;
            end
        end
    end

    assign w_dark = w_blank_sel | (bus.lz_en & w_zsup);

    sevenseg_font u_font (
        .i_nibble (w_nib),
        .o_seg    (w_font_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_seg        <= SEG_DARK;
            r_dp         <= 1'b1;
            r_an         <= '1;
        end else begin
            r_frame_tick <= w_wrap;

            if (w_term) begin
                r_presc <= '0;
                r_idx   <= w_wrap ? '0 : r_idx + IW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (w_wrap && r_pending) begin
                r_act_val   <= r_pend_val;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
            end

            // A load coinciding with a wrap stays pending for the next frame.
            if (bus.load) begin
                r_pend_val   <= bus.value;
                r_pend_dp    <= bus.dp_in;
                r_pend_blank <= bus.blank_in;
                r_pending    <= 1'b1;
            end else if (w_wrap) begin
                r_pending    <= 1'b0;
            end

            // Segments, dp and anode all come from the same pre-edge index.
            r_seg <= w_dark ? SEG_DARK : w_font_seg;
            r_dp  <= ~w_dp_sel;
            r_an  <= ~(DIGITS'(1) << r_idx);
        end
    end

    assign bus.pending    = r_pending;
    assign bus.frame_tick = r_frame_tick;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
endmodule
